// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer_if
//  Description : Load-side valid/ready handshake bundle for piso_serializer.
//                master = word producer, slave = serializer.
//  Revision    : 1.0  initial release
// ============================================================================
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in, serial-out transmitter. Accepts a WIDTH-bit
//                word over a valid/ready handshake and shifts it out MSB
//                first, one bit per clk. Provides registered sdo, sdo_n and
//                frame outputs, plus a one-cycle done pulse after each frame.
//                Optional even-parity bit appended after the LSB when the
//                macro PISO_PARITY_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    Reset,
    piso_serializer_if.slave        load_if,
    output logic                    sdo,
    output logic                    sdo_n,
    output logic                    frame,
    output logic                    done
);

`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state;
    logic [FRAME_LEN-1:0]   shreg;
    logic [CNT_W-1:0]       cnt;
    logic [FRAME_LEN-1:0]   frame_word;
    logic                   ready;
    logic                   xfer;

    // Full serial frame for the offered word: data, then parity if enabled.
`ifdef PISO_PARITY_EN
    assign frame_word = {load_if.load_data, ^load_if.load_data};
`else
    assign frame_word = load_if.load_data;
`endif

    // Ready in IDLE and on the final frame cycle; counter is zero in IDLE,
    // so the counter test alone covers the SHIFT case.
    assign ready             = (state == IDLE) || (cnt == '0);
    assign load_if.load_ready = ready;
    assign xfer              = load_if.load_valid && ready;

    // Frame sequencer: loads, shifts MSB-first, and drives registered outputs.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
            sdo   <= 1'b1;
            sdo_n <= 1'b0;
            frame <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        state <= SHIFT;
                        shreg <= frame_word << 1;
                        cnt   <= LAST_IDX;
                        sdo   <= frame_word[FRAME_LEN-1];
                        sdo_n <= ~frame_word[FRAME_LEN-1];
                        frame <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        sdo   <= shreg[FRAME_LEN-1];
                        sdo_n <= ~shreg[FRAME_LEN-1];
                        shreg <= shreg << 1;
                        cnt   <= cnt - 1'b1;
                    end else begin
                        // Final cycle: reload back-to-back or fall idle.
                        done <= 1'b1;
                        if (xfer) begin
                            shreg <= frame_word << 1;
                            cnt   <= LAST_IDX;
                            sdo   <= frame_word[FRAME_LEN-1];
                            sdo_n <= ~frame_word[FRAME_LEN-1];
                            frame <= 1'b1;
                        end else begin
                            state <= IDLE;
                            shreg <= '0;
                            sdo   <= 1'b1;
                            sdo_n <= 1'b0;
                            frame <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Self-checking bench for piso_serializer. A queue of pending
//                serial bits predicts sdo/sdo_n/frame/done/load_ready every
//                cycle; directed scenarios are followed by random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_piso_serializer;

    localparam int WIDTH = 8;

    logic clk;
    logic Reset;
    logic sdo;
    logic sdo_n;
    logic frame;
    logic done;

    int errors = 0;
    int checks = 0;

    // Model state: bits still to appear on sdo, head is the bit on the line now.
    bit q[$];
    bit exp_done;

    piso_serializer_if #(.WIDTH(WIDTH)) bus ();

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .Reset   (Reset),
        .load_if (bus),
        .sdo     (sdo),
        .sdo_n   (sdo_n),
        .frame   (frame),
        .done    (done)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Append the serial image of a word: MSB first, then optional parity.
    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) q.push_back(w[i]);
`ifdef PISO_PARITY_EN
        q.push_back(^w);
`endif
    endtask

    task automatic check_outputs(input string tag);
        logic e_sdo;
        e_sdo = (q.size() != 0) ? q[0] : 1'b1;
        chk({tag, ".sdo"},        sdo,           e_sdo);
        chk({tag, ".sdo_n"},      sdo_n,         ~e_sdo);
        chk({tag, ".frame"},      frame,         q.size() != 0);
        chk({tag, ".done"},       done,          exp_done);
        chk({tag, ".load_ready"}, bus.load_ready, q.size() <= 1);
    endtask

    // One clock: decide transfer from the model, advance, check at negedge.
    task automatic tick(input string tag);
        bit               xfer;
        bit               busy;
        logic [WIDTH-1:0] w;
        xfer = bus.load_valid && (q.size() <= 1);
        w    = bus.load_data;
        @(posedge clk);
        busy = q.size() != 0;
        if (busy) void'(q.pop_front());
        exp_done = busy && (q.size() == 0);
        if (xfer) push_word(w);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic send(input logic [WIDTH-1:0] w, input string tag);
        bus.load_valid = 1'b1;
        bus.load_data  = w;
        tick(tag);
        bus.load_valid = 1'b0;
        bus.load_data  = WIDTH'($urandom);
    endtask

    task automatic idle_ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    // Directed scenarios followed by random traffic.
    initial begin
        logic [WIDTH-1:0] seen;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        exp_done       = 1'b0;
        Reset          = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs("reset_init");
        Reset = 1'b1;
        idle_ticks(2, "idle");

        // Single word 0xA5; also reassemble the frame bits directly.
        send(8'hA5, "a5");
        seen = '0;
        seen = {seen[WIDTH-2:0], sdo};
        for (int i = 1; i < WIDTH; i++) begin
            tick("a5");
            seen = {seen[WIDTH-2:0], sdo};
        end
`ifndef PISO_PARITY_EN
        chk("a5.word_bit7", seen[7], 1'b1);
        chk("a5.word_bit6", seen[6], 1'b0);
        chk("a5.word_bit0", seen[0], 1'b1);
        tick("a5_done");
        chk("a5.done_pulse", done, 1'b1);
`endif
        idle_ticks(4, "a5_tail");

        // Back-to-back 0xFF then 0x00 with valid held.
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hFF;
        tick("b2b");
        while (!(q.size() == 1)) tick("b2b");
        bus.load_data = 8'h00;
        tick("b2b_second");
        bus.load_valid = 1'b0;
        idle_ticks(WIDTH + 3, "b2b_tail");

        // Busy-ignore: offer 0xFF while 0x3C is shifting.
        send(8'h3C, "busy");
        idle_ticks(2, "busy");
        chk("busy.ready_low", bus.load_ready, 1'b0);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'hFF;
        for (int i = 0; i < WIDTH + 2 && q.size() > 1; i++) tick("busy_hold");
        tick("busy_accept");
        bus.load_valid = 1'b0;
        idle_ticks(WIDTH + 3, "busy_tail");

        // Reset mid-frame while bit 3 of 0x81 is on sdo.
        send(8'h81, "rst_mid");
        idle_ticks(4, "rst_mid");
        Reset = 1'b0;
        #1;
        q.delete();
        exp_done = 1'b0;
        check_outputs("rst_async");
        tick("rst_hold");
        Reset = 1'b1;
        idle_ticks(2, "rst_after");
        send(8'h81, "rst_resend");
        idle_ticks(WIDTH + 2, "rst_resend");

        // Parity words (model appends ^w when enabled).
        send(8'h07, "par07");
        idle_ticks(WIDTH + 2, "par07");
        send(8'h03, "par03");
        idle_ticks(WIDTH + 2, "par03");

        // Random traffic, with occasional async reset.
        for (int i = 0; i < 400; i++) begin
            bus.load_valid = ($urandom_range(0, 3) != 0);
            bus.load_data  = WIDTH'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                Reset = 1'b0;
                #1;
                q.delete();
                exp_done = 1'b0;
                check_outputs("rnd_rst");
                Reset = 1'b1;
            end
            tick("rnd");
        end
        bus.load_valid = 1'b0;
        idle_ticks(WIDTH + 3, "final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter. It is the driving end for the flip-flop and shift-register receivers in the typical-circuit-blocks collection. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clk. It provides a true output, a complementary output and a frame qualifier, so a downstream DFF-based deserializer can capture the word.

## Interface
- WIDTH, 8: word length in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- load_valid  input  1  load_data is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word to transmit.
- sdo  output  1  serial data, MSB first; idles high.
- sdo_n  output  1  always ~sdo, registered alongside sdo.
- frame  output  1  high during every cycle in which sdo carries a frame bit.
- done  output  1  one-cycle pulse after the last bit of a frame.

## Operation
- Clock is clk; reset is Reset, asynchronous, active-low.
- Reset values:
  - sdo=1, sdo_n=0, frame=0, done=0.
  - load_ready=1.
  - State=IDLE; shift register and bit counter cleared.
- Transfer occurs on any rising edge where load_valid && load_ready.
- N is the frame length: N = WIDTH, or WIDTH+1 with parity enabled (see Configuration).
- States:
  - IDLE:
    - load_ready=1, frame=0, sdo=1.
    - On transfer: capture load_data and load the counter with N-1. Go to SHIFT.
  - SHIFT:
    - sdo = current MSB of the shift register; frame=1.
    - Each edge, shift left by one and decrement the counter.
    - load_ready=0, except in the final frame cycle (counter==0), where load_ready=1.
    - At the end of the final cycle:
      - With a transfer: reload, stay in SHIFT, pulse done.
      - Without a transfer: go to IDLE, pulse done.
- load_ready is combinational from state and counter only. It never depends on load_valid.
- load_valid and load_data are ignored while load_ready=0. Changing load_data mid-frame must not alter sdo.
- Bit counter width is $clog2(WIDTH+1) and must not wrap below 0.
- Reset asserted mid-frame:
  - Outputs go to reset values immediately and the frame is abandoned.
  - No done pulse.
  - The first transfer after Reset deasserts behaves normally.

## Timing
- Transfer at edge k:
  - Bit WIDTH-1 drives sdo and frame from edge k through edge k+1.
  - Bit WIDTH-1-j is driven in the cycle after edge k+j, for j = 0..WIDTH-1.
- Latency from handshake to first serial bit: 1 clk. sdo, sdo_n and frame are registered.
- The final frame bit occupies the cycle after edge k+N-1.
- done is high for exactly the cycle after edge k+N.
- Back-to-back: a transfer at edge k+N keeps frame high continuously.
  - The new MSB appears after edge k+N, the same cycle as done.
  - Sustained throughput is one word per N cycles.
- Idle gap: at least 1 cycle with frame=0 whenever no transfer occurs at edge k+N.

## Configuration
- Macro PISO_PARITY_EN.
  - Defined: one even-parity bit (^word) is appended after the LSB. N=WIDTH+1, frame covers the parity cycle, and done follows the parity bit.
  - Undefined: no parity logic. N=WIDTH.

## Test plan
- Reset check (WIDTH=8): assert Reset mid-simulation. Expect sdo=1, sdo_n=0, frame=0, done=0, load_ready=1 immediately, without waiting for a clk edge.
- Single word, no parity: transfer 0xA5.
  - sdo sequence over 8 cycles: 1,0,1,0,0,1,0,1, with sdo_n its complement and frame high for exactly those 8 cycles.
  - done high for 1 cycle after the 8th bit, then IDLE.
- Back-to-back: hold load_valid=1 with 0xFF, then 0x00.
  - frame high for 16 contiguous cycles; sdo is 8 ones then 8 zeros.
  - Two done pulses, the first coinciding with the 0x00 MSB cycle.
- Busy-ignore: while bit 5 of 0x3C is on sdo, drive load_valid=1 with load_data=0xFF.
  - load_ready=0 and the 0x3C bit stream is unchanged.
  - The new word is accepted only on the final-bit edge.
- Reset mid-frame: assert Reset during bit 3 of 0x81.
  - Immediate idle outputs and no done.
  - After release, transfer 0x81 and expect the full 1,0,0,0,0,0,0,1 stream.
- PISO_PARITY_EN defined: transfer 0x07.
  - 9 frame cycles: 0,0,0,0,0,1,1,1, then parity 1.
  - done after cycle 9. Transfer 0x03: parity bit 0.
